// File: rtl/dcache_pkg.sv
// Shared types and address-split helpers for the direct-mapped data cache.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WRITE,
        DONE
    } state_e;

    localparam int OFFSET_W = 2;

    function automatic int idx_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(input int sets, input int data_width);
        return data_width - $clog2(sets) - OFFSET_W;
    endfunction

endpackage

// File: rtl/dcache_line_store.sv
// Valid/tag/data arrays for the one-word-per-line data cache.
module dcache_line_store
    import dcache_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SETS       = 8,
    localparam int IW        = idx_w(SETS),
    localparam int TW        = tag_w(SETS, DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IW-1:0]         rd_idx_i,
    output logic                  rd_valid_o,
    output logic [TW-1:0]         rd_tag_o,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    input  logic                  wr_en_i,
    input  logic                  wr_byte_i,
    input  logic                  wr_fill_i,
    input  logic [IW-1:0]         wr_idx_i,
    input  logic [OFFSET_W-1:0]   wr_off_i,
    input  logic [TW-1:0]         wr_tag_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i
);

    logic [SETS-1:0]                 valid_q, valid_d;
    logic [SETS-1:0][TW-1:0]         tag_q, tag_d;
    logic [SETS-1:0][DATA_WIDTH-1:0] data_q, data_d;

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i];

    // Only a refill allocates a line; store hits touch data alone.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (wr_en_i) begin
            if (wr_fill_i) begin
                valid_d[wr_idx_i] = 1'b1;
                tag_d[wr_idx_i]   = wr_tag_i;
            end
            if (wr_byte_i) begin
                data_d[wr_idx_i][{wr_off_i, 3'b000} +: 8] = wr_data_i[7:0];
            end else begin
                data_d[wr_idx_i] = wr_data_i;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule

// File: rtl/dcache_direct.sv
// Direct-mapped write-through no-write-allocate data cache.
// Define DCACHE_STATS_EN to add load hit/miss counters.
module dcache_direct
    import dcache_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SETS       = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req_i,
    input  logic                  cpu_we_i,
    input  logic                  cpu_byte_i,
    input  logic [DATA_WIDTH-1:0] cpu_addr_i,
    input  logic [DATA_WIDTH-1:0] cpu_wdata_i,
    output logic [DATA_WIDTH-1:0] cpu_rdata_o,
    output logic                  cpu_stall_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic                  mem_byte_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_ack_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
`ifdef DCACHE_STATS_EN
    ,
    output logic [DATA_WIDTH-1:0] hit_count_o,
    output logic [DATA_WIDTH-1:0] miss_count_o
`endif
);

    localparam int IW = idx_w(SETS);
    localparam int TW = tag_w(SETS, DATA_WIDTH);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic                  byte_q, byte_d;
    logic                  we_q, we_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic                  mem_byte_q, mem_byte_d;
    logic [DATA_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

    logic [IW-1:0]         cpu_idx, rd_idx, wr_idx;
    logic [TW-1:0]         cpu_tag, rd_tag, wr_tag;
    logic [OFFSET_W-1:0]   cpu_off, sel_off, wr_off;
    logic [DATA_WIDTH-1:0] rd_data, wr_data, line_word;
    logic                  rd_valid, hit, load_hit, load_miss;
    logic                  wr_en, wr_byte, wr_fill, stall, sel_byte;
    logic [7:0]            sel_lane;

    assign cpu_off = cpu_addr_i[OFFSET_W-1:0];
    assign cpu_idx = cpu_addr_i[IW+OFFSET_W-1:OFFSET_W];
    assign cpu_tag = cpu_addr_i[DATA_WIDTH-1:IW+OFFSET_W];

    // Outside IDLE the array is read at the latched request address.
    assign rd_idx = (state_q == IDLE) ? cpu_idx
                                      : addr_q[IW+OFFSET_W-1:OFFSET_W];

    dcache_line_store #(
        .DATA_WIDTH(DATA_WIDTH),
        .SETS      (SETS)
    ) u_lines (
        .clk       (clk),
        .rst       (rst),
        .rd_idx_i  (rd_idx),
        .rd_valid_o(rd_valid),
        .rd_tag_o  (rd_tag),
        .rd_data_o (rd_data),
        .wr_en_i   (wr_en),
        .wr_byte_i (wr_byte),
        .wr_fill_i (wr_fill),
        .wr_idx_i  (wr_idx),
        .wr_off_i  (wr_off),
        .wr_tag_i  (wr_tag),
        .wr_data_i (wr_data)
    );

    assign hit       = rd_valid && (rd_tag == cpu_tag);
    assign load_hit  = (state_q == IDLE) && cpu_req_i && !cpu_we_i && hit;
    assign load_miss = (state_q == IDLE) && cpu_req_i && !cpu_we_i && !hit;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        byte_d      = byte_q;
        we_d        = we_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_byte_d  = mem_byte_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        stall       = 1'b0;
        wr_en       = 1'b0;
        wr_byte     = 1'b0;
        wr_fill     = 1'b0;
        wr_idx      = cpu_idx;
        wr_off      = cpu_off;
        wr_tag      = cpu_tag;
        wr_data     = cpu_wdata_i;
        unique case (state_q)
            IDLE: begin
                if (cpu_req_i && (cpu_we_i || !hit)) begin
                    stall       = 1'b1;
                    addr_d      = cpu_addr_i;
                    byte_d      = cpu_byte_i;
                    we_d        = cpu_we_i;
                    mem_req_d   = 1'b1;
                    mem_we_d    = cpu_we_i;
                    mem_byte_d  = cpu_we_i && cpu_byte_i;
                    mem_addr_d  = cpu_we_i ? cpu_addr_i
                                           : {cpu_addr_i[DATA_WIDTH-1:OFFSET_W],
                                              {OFFSET_W{1'b0}}};
                    mem_wdata_d = cpu_wdata_i;
                    state_d     = cpu_we_i ? WRITE : FILL;
                    wr_en       = cpu_we_i && hit;
                    wr_byte     = cpu_byte_i;
                end
            end
            FILL: begin
                stall = 1'b1;
                if (mem_ack_i) begin
                    wr_en     = 1'b1;
                    wr_fill   = 1'b1;
                    wr_idx    = addr_q[IW+OFFSET_W-1:OFFSET_W];
                    wr_tag    = addr_q[DATA_WIDTH-1:IW+OFFSET_W];
                    wr_data   = mem_rdata_i;
                    mem_req_d = 1'b0;
                    state_d   = DONE;
                end
            end
            WRITE: begin
                stall = 1'b1;
                if (mem_ack_i) begin
                    mem_req_d  = 1'b0;
                    mem_we_d   = 1'b0;
                    mem_byte_d = 1'b0;
                    state_d    = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign sel_off  = (state_q == IDLE) ? cpu_off : addr_q[OFFSET_W-1:0];
    assign sel_byte = (state_q == IDLE) ? cpu_byte_i : byte_q;

    always_comb begin
        line_word = '0;
        if (load_hit || (state_q == DONE && !we_q)) begin
            line_word = rd_data;
        end
    end

    assign sel_lane    = line_word[{sel_off, 3'b000} +: 8];
    assign cpu_rdata_o = sel_byte ? {{(DATA_WIDTH-8){1'b0}}, sel_lane}
                                  : line_word;

    // Gating by rst keeps a held miss request from stalling during reset.
    assign cpu_stall_o = stall && !rst;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_byte_o  = mem_byte_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            byte_q      <= 1'b0;
            we_q        <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_byte_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            byte_q      <= byte_d;
            we_q        <= we_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_byte_q  <= mem_byte_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

`ifdef DCACHE_STATS_EN
    logic [DATA_WIDTH-1:0] hit_cnt_q, hit_cnt_d;
    logic [DATA_WIDTH-1:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q + DATA_WIDTH'(load_hit);
        miss_cnt_d = miss_cnt_q + DATA_WIDTH'(load_miss);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_count_o  = hit_cnt_q;
    assign miss_count_o = miss_cnt_q;
`else
    logic unused_miss;
    assign unused_miss = load_miss;
`endif

endmodule

// File: tb/tb_dcache_direct.sv
// Directed self-checking bench for dcache_direct with a load-data scoreboard.
module tb_dcache_direct;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic        cpu_byte = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        mem_req;
    logic        mem_we;
    logic        mem_byte;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    dcache_direct #(
        .DATA_WIDTH(32),
        .SETS      (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req_i  (cpu_req),
        .cpu_we_i   (cpu_we),
        .cpu_byte_i (cpu_byte),
        .cpu_addr_i (cpu_addr),
        .cpu_wdata_i(cpu_wdata),
        .cpu_rdata_o(cpu_rdata),
        .cpu_stall_o(cpu_stall),
        .mem_req_o  (mem_req),
        .mem_we_o   (mem_we),
        .mem_byte_o (mem_byte),
        .mem_addr_o (mem_addr),
        .mem_wdata_o(mem_wdata),
        .mem_ack_i  (mem_ack),
        .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic chk_rdata(input string tag);
        logic [31:0] e;
        chk({tag, "_sb"}, 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk(tag, cpu_rdata, e);
        end
    endtask

    task automatic do_load(input string tag, input logic [31:0] a,
                           input logic b, input bit hit, input int dly,
                           input logic [31:0] fill, input logic [31:0] expd);
        exp_q.push_back(expd);
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_byte = b; cpu_addr = a;
        @(negedge clk);
        chk({tag, "_stall"}, 32'(cpu_stall), hit ? 32'd0 : 32'd1);
        if (hit) begin
            chk_rdata({tag, "_hit"});
            @(posedge clk); #1;
            cpu_req = 1'b0;
        end else begin
            for (int k = 1; k <= dly; k++) begin
                @(posedge clk); #1;
                mem_ack = (k == dly); mem_rdata = fill;
                @(negedge clk);
                chk({tag, "_fstall"}, 32'(cpu_stall), 32'd1);
                chk({tag, "_freq"}, 32'(mem_req), 32'd1);
                if (k == 1) begin
                    chk({tag, "_fwe"}, 32'(mem_we), 32'd0);
                    chk({tag, "_faddr"}, mem_addr, {a[31:2], 2'b00});
                end
            end
            @(posedge clk); #1;
            mem_ack = 1'b0; cpu_req = 1'b0;
            @(negedge clk);
            chk({tag, "_dstall"}, 32'(cpu_stall), 32'd0);
            chk({tag, "_dreq"}, 32'(mem_req), 32'd0);
            chk_rdata({tag, "_done"});
        end
    endtask

    task automatic do_store(input string tag, input logic [31:0] a,
                            input logic b, input int dly,
                            input logic [31:0] wd);
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_byte = b;
        cpu_addr = a; cpu_wdata = wd;
        @(negedge clk);
        chk({tag, "_stall"}, 32'(cpu_stall), 32'd1);
        for (int k = 1; k <= dly; k++) begin
            @(posedge clk); #1;
            mem_ack = (k == dly);
            cpu_req = 1'b0; cpu_we = 1'b0;
            @(negedge clk);
            chk({tag, "_wstall"}, 32'(cpu_stall), 32'd1);
            chk({tag, "_wreq"}, 32'(mem_req), 32'd1);
            chk({tag, "_wwe"}, 32'(mem_we), 32'd1);
            chk({tag, "_wbyte"}, 32'(mem_byte), 32'(b));
            chk({tag, "_waddr"}, mem_addr, a);
            chk({tag, "_wdata"}, mem_wdata, wd);
        end
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk);
        chk({tag, "_dstall"}, 32'(cpu_stall), 32'd0);
        chk({tag, "_dreq"}, 32'(mem_req), 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", 32'(cpu_stall), 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_byte", 32'(mem_byte), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_rdata", cpu_rdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        do_load("ld100_miss", 32'h100, 1'b0, 1'b0, 3, 32'hDEADBEEF, 32'hDEADBEEF);
        do_load("ld100_hit", 32'h100, 1'b0, 1'b1, 0, 32'h0, 32'hDEADBEEF);
        do_load("lbu102_hit", 32'h102, 1'b1, 1'b1, 0, 32'h0, 32'h000000AD);
        do_store("sb101", 32'h101, 1'b1, 1, 32'hFFFFFF55);
        do_load("ld100_sb", 32'h100, 1'b0, 1'b1, 0, 32'h0, 32'hDEAD55EF);
        do_load("ld120_miss", 32'h120, 1'b0, 1'b0, 2, 32'hCAFEF00D, 32'hCAFEF00D);
        do_load("ld120_hit", 32'h120, 1'b0, 1'b1, 0, 32'h0, 32'hCAFEF00D);
        do_load("ld100_evict", 32'h100, 1'b0, 1'b0, 1, 32'h11112222, 32'h11112222);
        do_store("sw200_miss", 32'h200, 1'b0, 2, 32'hA5A5A5A5);
        do_load("ld100_keep", 32'h100, 1'b0, 1'b1, 0, 32'h0, 32'h11112222);
        do_load("ld200_miss", 32'h200, 1'b0, 1'b0, 1, 32'h77778888, 32'h77778888);
        do_load("lbu203_hit", 32'h203, 1'b1, 1'b1, 0, 32'h0, 32'h00000077);

        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_byte = 1'b0; cpu_addr = 32'h100;
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_req_pre", 32'(mem_req), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_req", 32'(mem_req), 32'd0);
        chk("abort_stall", 32'(cpu_stall), 32'd0);
        @(posedge clk); #1;
        cpu_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        do_load("ld100_postrst", 32'h100, 1'b0, 1'b0, 1, 32'h00000003, 32'h00000003);

        chk("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
